// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size encodings and
// the byte-lane shift that goes with each access size.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  // The accessed bytes sit at the top of the big-endian doubleword; this is
  // how far they must move to become right-justified.
  function automatic logic [5:0] lane_shift(input logic [1:0] size);
    case (size)
      SIZE_B:  lane_shift = 6'd56;
      SIZE_H:  lane_shift = 6'd48;
      SIZE_W:  lane_shift = 6'd32;
      default: lane_shift = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: extracts and extends load data from the top
// of a doubleword, and merges store data into the top lanes of a doubleword.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] i_dword,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_load,
  output logic [63:0] o_merge
);

  function automatic logic [63:0] extend_load(input logic [63:0] dw,
                                              input logic [5:0]  sh,
                                              input logic        uns);
    logic signed [63:0] s;
    s = signed'(dw);
    if (uns) extend_load = dw >> sh;
    else     extend_load = s >>> sh;
  endfunction

  function automatic logic [63:0] merge_store(input logic [63:0] dw,
                                              input logic [63:0] wd,
                                              input logic [5:0]  sh);
    logic [63:0] mask;
    mask        = {64{1'b1}} << sh;
    merge_store = (dw & ~mask) | ((wd << sh) & mask);
  endfunction

  logic [5:0] w_shift;

  assign w_shift = lane_shift(i_size);
  assign o_load  = extend_load(i_dword, w_shift, i_unsigned);
  assign o_merge = merge_store(i_dword, i_wdata, w_shift);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a combinational-read,
// big-endian data memory; sub-doubleword stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_read_data
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdword;
  logic [63:0] r_rdata;

  logic [63:0] w_load;
  logic [63:0] w_merge;
  logic [63:0] w_store_data;
  logic [63:0] w_resp;
  logic        w_accept;

  // The memory decodes only the low address bits; the full address is forwarded.
  logic [MEM_ADDR_BITS-1:0] w_unused_offset;
  assign w_unused_offset = r_addr[MEM_ADDR_BITS-1:0];

  assign w_accept     = (r_state == ST_IDLE) && req_valid;
  assign w_store_data = (r_size == SIZE_D) ? r_wdata : w_merge;
  assign w_resp       = r_write ? 64'd0 : w_load;

  lsu_align u_align (
    .i_dword    (r_rdword),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Outputs are gated by reset so an aborted access never reaches memory.
  always_comb begin
    w_next         = r_state;
    req_ready      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 64'd0;
    mem_write_data = 64'd0;
    resp_valid     = 1'b0;
    resp_rdata     = r_rdata;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          w_next = (req_write && (req_size == SIZE_D)) ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        w_next = r_write ? ST_WRITE : ST_RESP;
        if (!reset) begin
          mem_read    = 1'b1;
          mem_address = r_addr;
        end
      end
      ST_WRITE: begin
        w_next = ST_RESP;
        if (!reset) begin
          mem_write      = 1'b1;
          mem_address    = r_addr;
          mem_write_data = w_store_data;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
        if (!reset) begin
          resp_valid = 1'b1;
          resp_rdata = w_resp;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write    <= req_write;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end
    if (r_state == ST_READ) r_rdword <= mem_read_data;
  end

  // Holds the last response so resp_rdata is stable between completions.
  always_ff @(posedge clk) begin
    if (reset)                   r_rdata <= 64'd0;
    else if (r_state == ST_RESP) r_rdata <= w_resp;
  end

endmodule
